dino_jump_ctrl: RTL and testbench
=================================

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 833334, meaning clk cycles per frame tick (60 Hz at 50 MHz).
REQ-002 Parameter GROUND_Y, default 106, meaning dino resting Y in pixels.
REQ-003 Parameter CEIL_Y, default 40, meaning minimum allowed Y (top clamp).
REQ-004 Parameter V0, default 6, meaning launch velocity in pixels/tick.
REQ-005 Parameter GRAV, default 1, meaning velocity change per tick.
REQ-006 Parameter VMAX, default 8, meaning fall velocity limit.
REQ-007 clk  input  1  system clock.
REQ-008 resetn  input  1  reset; synchronous, active-low.
REQ-009 enable  input  1  high = run; low = freeze physics (pause or game over).
REQ-010 jump  input  1  jump key level, active-high, already synchronised.
REQ-011 height  output  16  dino top Y in pixels; bits [15:7] always 0; feeds the dino datapath height input.
REQ-012 airborne  output  1  high in RISE or FALL.
REQ-013 frame_tick  output  1  one-cycle pulse per frame.
REQ-014 land  output  1  one-cycle pulse on the tick that returns the dino to ground.

Function
REQ-015 The tick counter SHALL count 0..TICK_DIV-1 while enable=1, wrap to 0, and assert frame_tick for exactly the cycle the count equals TICK_DIV-1.
REQ-016 With enable=0 the counter SHALL hold, frame_tick=0, and height/state/velocity SHALL hold.
REQ-017 A rising edge of jump (jump=1, previous-cycle jump=0) while enable=1 SHALL set a pending request; an edge in the same cycle as frame_tick SHALL be honoured on that tick.
REQ-018 Edges while enable=0 SHALL be ignored; the pending request SHALL clear on every frame_tick.
REQ-019 States GROUND, RISE, FALL SHALL be the only states; all transitions occur only on frame_tick.
REQ-020 GROUND on tick with request: vel=V0, go to RISE, height unchanged; without request: stay, height=GROUND_Y.
REQ-021 RISE on tick: if height-vel < CEIL_Y then height=CEIL_Y, vel=0, go FALL; else height-=vel, and if vel<=GRAV then vel=0, go FALL, else vel-=GRAV.
REQ-022 FALL on tick: vn=min(vel+GRAV, VMAX); if height+vn >= GROUND_Y then height=GROUND_Y, vel=0, go GROUND, pulse land; else height+=vn, vel=vn.
REQ-023 Jump requests in RISE or FALL SHALL be discarded (no double jump, no buffering).
REQ-024 Height arithmetic SHALL be unsigned 7-bit with the compare done before subtraction so no underflow or overflow occurs; vel SHALL be 4-bit unsigned.
REQ-025 height, airborne and land SHALL update registered, one cycle after the frame_tick cycle; land SHALL be high for exactly that one cycle.
REQ-026 Elaboration SHALL fail if CEIL_Y >= GROUND_Y, GROUND_Y > 119, V0 > 15, VMAX > 15, or GRAV = 0.

Reset
REQ-027 On resetn=0 at a clk edge: state=GROUND, height=GROUND_Y, vel=0, counter=0, pending=0, previous-jump register=0, airborne=0, frame_tick=0, land=0.
REQ-028 Reset mid-jump SHALL return the dino to GROUND_Y on the next edge with no land pulse.

Structure
REQ-029 GROUND_Y, SCREEN_H=120, TICK_DIV_60HZ=833334 and the jump-state enum SHALL live in the shared package dino_game_pkg.
REQ-030 The tick counter SHALL be a sub-module frame_tick_gen (ports clk, resetn, enable, tick), reusable by the obstacle stage.
REQ-031 Physics FSM and jump-edge logic SHALL stay in dino_jump_ctrl; expected size 120-250 lines.

Verification (TICK_DIV=4 for simulation)
REQ-032 Idle: reset, enable=1, jump=0 for 40 cycles -> height=106, airborne=0, frame_tick every 4th cycle, land never.
REQ-033 Single jump, defaults: after the launch tick, heights per tick = 100,95,91,88,86,85,86,88,91,95,100,106; land pulses once on the 106 tick; airborne falls with it.
REQ-034 Ceiling clamp: CEIL_Y=98, V0=6 -> heights 100, 98, then fall 99,101,104,106.
REQ-035 Held or repeated jump: jump held high through a full jump -> exactly one jump; an edge in FALL -> ignored, no re-launch after landing without a new edge.
REQ-036 Pause: enable=0 mid-RISE for 20 cycles -> height, counter frozen, no frame_tick; on resume the sequence continues unchanged.
REQ-037 Reset mid-air at height 88 -> next cycle height=106, airborne=0, land=0, counter=0.

Source files
------------

// File: rtl/dino_game_pkg.sv
// rtl/dino_game_pkg.sv - shared screen geometry, frame rate and jump-state encoding for the dino game
package dino_game_pkg;

  localparam int SCREEN_H      = 120;
  localparam int GROUND_Y      = 106;
  localparam int TICK_DIV_60HZ = 833334;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } jump_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - frame tick divider, one-cycle tick per TICK_DIV enabled clocks
module frame_tick_gen
  import dino_game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_60HZ
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("frame_tick_gen: TICK_DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pausing freezes the count and suppresses the tick even when parked on LAST.
  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - dino jump physics: edge-detected jump request, GROUND/RISE/FALL per frame tick
module dino_jump_ctrl #(
  parameter int TICK_DIV = dino_game_pkg::TICK_DIV_60HZ,
  parameter int GROUND_Y = dino_game_pkg::GROUND_Y,
  parameter int CEIL_Y   = 40,
  parameter int V0       = 6,
  parameter int GRAV     = 1,
  parameter int VMAX     = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        jump,
  output logic [15:0] height,
  output logic        airborne,
  output logic        frame_tick,
  output logic        land
);

  if (CEIL_Y >= GROUND_Y || GROUND_Y > dino_game_pkg::SCREEN_H - 1 || V0 > 15 ||
      VMAX > 15 || GRAV == 0 || GRAV > 15) begin : g_bad_params
    $error("dino_jump_ctrl: illegal geometry or velocity parameters");
  end

  localparam logic [6:0] GROUND_H = 7'(GROUND_Y);
  localparam logic [6:0] CEIL_H   = 7'(CEIL_Y);
  localparam logic [3:0] V0_V     = 4'(V0);
  localparam logic [3:0] GRAV_V   = 4'(GRAV);
  localparam logic [4:0] VMAX_W   = 5'(VMAX);

  dino_game_pkg::jump_state_e state_q, state_d;
  logic [6:0] height_q, height_d;
  logic [3:0] vel_q, vel_d;
  logic       airborne_q, airborne_d;
  logic       land_q, land_d;
  logic       pending_q, pending_d;
  logic       jump_prev_q;

  logic       jump_edge, launch_req;
  logic       rise_clamp, rise_stop, fall_land;
  logic [4:0] vel_up;
  logic [3:0] vel_fall;

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .enable(enable),
    .tick  (frame_tick)
  );

  // An edge landing on the tick cycle itself is honoured via launch_req directly.
  assign jump_edge  = enable && jump && !jump_prev_q;
  assign launch_req = pending_q || jump_edge;

  always_comb begin
    pending_d = pending_q;
    if (frame_tick) begin
      pending_d = 1'b0;
    end else if (jump_edge) begin
      pending_d = 1'b1;
    end
  end

  // Compares are widened to 8 bits and done before any subtract, so 7-bit height never wraps.
  always_comb begin
    rise_clamp = {1'b0, height_q} < ({4'b0, vel_q} + {1'b0, CEIL_H});
    rise_stop  = vel_q <= GRAV_V;
    vel_up     = {1'b0, vel_q} + {1'b0, GRAV_V};
    vel_fall   = (vel_up > VMAX_W) ? VMAX_W[3:0] : vel_up[3:0];
    fall_land  = ({1'b0, height_q} + {4'b0, vel_fall}) >= {1'b0, GROUND_H};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= dino_game_pkg::ST_GROUND;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        dino_game_pkg::ST_GROUND: if (launch_req) state_d = dino_game_pkg::ST_RISE;
        dino_game_pkg::ST_RISE:   if (rise_clamp || rise_stop) state_d = dino_game_pkg::ST_FALL;
        dino_game_pkg::ST_FALL:   if (fall_land) state_d = dino_game_pkg::ST_GROUND;
        default:                  state_d = dino_game_pkg::ST_GROUND;
      endcase
    end
  end

  always_comb begin
    height_d   = height_q;
    vel_d      = vel_q;
    airborne_d = airborne_q;
    land_d     = 1'b0;
    if (frame_tick) begin
      airborne_d = (state_d != dino_game_pkg::ST_GROUND);
      case (state_q)
        dino_game_pkg::ST_GROUND: begin
          if (launch_req) begin
            vel_d = V0_V;
          end else begin
            height_d = GROUND_H;
            vel_d    = 4'd0;
          end
        end
        dino_game_pkg::ST_RISE: begin
          if (rise_clamp) begin
            height_d = CEIL_H;
            vel_d    = 4'd0;
          end else begin
            height_d = height_q - {3'b0, vel_q};
            vel_d    = rise_stop ? 4'd0 : vel_q - GRAV_V;
          end
        end
        dino_game_pkg::ST_FALL: begin
          if (fall_land) begin
            height_d = GROUND_H;
            vel_d    = 4'd0;
            land_d   = 1'b1;
          end else begin
            height_d = height_q + {3'b0, vel_fall};
            vel_d    = vel_fall;
          end
        end
        default: begin
          height_d = GROUND_H;
          vel_d    = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      height_q    <= GROUND_H;
      vel_q       <= 4'd0;
      airborne_q  <= 1'b0;
      land_q      <= 1'b0;
      pending_q   <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      height_q    <= height_d;
      vel_q       <= vel_d;
      airborne_q  <= airborne_d;
      land_q      <= land_d;
      pending_q   <= pending_d;
      jump_prev_q <= jump;
    end
  end

  assign height   = {9'd0, height_q};
  assign airborne = airborne_q;
  assign land     = land_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb/tb_dino_jump_ctrl.sv - table-driven bench for dino_jump_ctrl (default and low-ceiling instances)
module tb_dino_jump_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] height, height_c;
  logic        airborne, airborne_c;
  logic        frame_tick, frame_tick_c;
  logic        land, land_c;

  always #5 clk = ~clk;

  dino_jump_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .jump(jump),
    .height(height), .airborne(airborne), .frame_tick(frame_tick), .land(land)
  );

  dino_jump_ctrl #(.TICK_DIV(4), .CEIL_Y(98)) dut_c (
    .clk(clk), .resetn(resetn), .enable(enable), .jump(jump),
    .height(height_c), .airborne(airborne_c), .frame_tick(frame_tick_c), .land(land_c)
  );

  typedef struct {
    int h;
    bit air;
    bit lnd;
    int hc;
    bit airc;
    bit lndc;
  } row_t;

  row_t tbl[13];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_tick(input string tag, output int waited);
    waited = 0;
    while (frame_tick !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (frame_tick !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_tick_timeout: got no frame_tick, expected one within 20 cycles", tag);
    end
    @(negedge clk);
  endtask

  task automatic ground_checks(input string tag, input bit chk_c);
    check({tag, "_height"}, height, 106);
    check({tag, "_airborne"}, airborne, 0);
    check({tag, "_land"}, land, 0);
    if (chk_c) begin
      check({tag, "_c_height"}, height_c, 106);
      check({tag, "_c_airborne"}, airborne_c, 0);
    end
  endtask

  // Starts at a cycle right after a tick; ends likewise.
  task automatic run_jump(input string tag, input int delay, input bit hold,
                          input int extra_row, input int pause_row);
    int w;
    int bad;
    bit chk_c;
    chk_c = (extra_row < 0);
    repeat (delay) @(negedge clk);
    jump = 1'b1;
    if (delay == 0) begin
      @(negedge clk);
      if (!hold) jump = 1'b0;
    end
    for (int r = 0; r < 13; r++) begin
      if (r == 1 && !hold) jump = 1'b0;
      if (r == extra_row) begin
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
      end
      if (r == pause_row) begin
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (frame_tick !== 1'b0 || height !== 16'(tbl[r-1].h) || land !== 1'b0) bad++;
          if (height_c !== 16'(tbl[r-1].hc)) bad++;
        end
        check($sformatf("%s_pause_frozen_errors", tag), bad, 0);
        enable = 1'b1;
      end
      next_tick(tag, w);
      if (r == pause_row) check($sformatf("%s_resume_latency", tag), w, 3);
      if (r == 0 && delay == 3) check($sformatf("%s_same_cycle_latency", tag), w, 0);
      check($sformatf("%s_h%0d", tag, r), height, tbl[r].h);
      check($sformatf("%s_air%0d", tag, r), airborne, tbl[r].air);
      check($sformatf("%s_land%0d", tag, r), land, tbl[r].lnd);
      if (chk_c) begin
        check($sformatf("%s_c_h%0d", tag, r), height_c, tbl[r].hc);
        check($sformatf("%s_c_air%0d", tag, r), airborne_c, tbl[r].airc);
        check($sformatf("%s_c_land%0d", tag, r), land_c, tbl[r].lndc);
      end
    end
    @(negedge clk);
    check({tag, "_land_one_cycle"}, land, 0);
    jump = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_tick(tag, w);
      ground_checks($sformatf("%s_after%0d", tag, k), chk_c);
    end
  endtask

  initial begin
    int hm[13] = '{106, 100, 95, 91, 88, 86, 85, 86, 88, 91, 95, 100, 106};
    int hc[13] = '{106, 100, 98, 99, 101, 104, 106, 106, 106, 106, 106, 106, 106};
    int bad_tick, bad_h, n_land, w;

    for (int r = 0; r < 13; r++) begin
      tbl[r].h    = hm[r];
      tbl[r].air  = (r < 12);
      tbl[r].lnd  = (r == 12);
      tbl[r].hc   = hc[r];
      tbl[r].airc = (r < 6);
      tbl[r].lndc = (r == 6);
    end

    resetn = 1'b0;
    enable = 1'b1;
    jump   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_height", height, 106);
    check("reset_upper_bits", height[15:7], 0);
    check("reset_airborne", airborne, 0);
    check("reset_land", land, 0);
    check("reset_frame_tick", frame_tick, 0);

    @(negedge clk);
    resetn = 1'b1;
    bad_tick = 0;
    bad_h    = 0;
    n_land   = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_tick !== ((i % 4) == 3)) bad_tick++;
      if (height !== 16'd106 || airborne !== 1'b0) bad_h++;
      if (land !== 1'b0) n_land++;
      @(negedge clk);
    end
    check("idle_tick_pattern_errors", bad_tick, 0);
    check("idle_height_errors", bad_h, 0);
    check("idle_land_pulses", n_land, 0);

    run_jump("single", 0, 1'b0, -1, -1);
    run_jump("held", 0, 1'b1, -1, -1);
    run_jump("pause", 0, 1'b0, -1, 3);
    run_jump("same_tick", 3, 1'b0, -1, -1);
    run_jump("fall_edge", 0, 1'b0, 8, -1);

    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    for (int r = 0; r < 5; r++) next_tick("midair", w);
    check("midair_height_before_reset", height, 88);
    check("midair_airborne_before_reset", airborne, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midair_reset_height", height, 106);
    check("midair_reset_airborne", airborne, 0);
    check("midair_reset_land", land, 0);
    check("midair_reset_frame_tick", frame_tick, 0);
    @(negedge clk);
    resetn = 1'b1;
    bad_tick = 0;
    n_land   = 0;
    for (int k = 0; k < 8; k++) begin
      if (frame_tick !== ((k % 4) == 3)) bad_tick++;
      if (land !== 1'b0 || height !== 16'd106) n_land++;
      @(negedge clk);
    end
    check("midair_counter_restart_errors", bad_tick, 0);
    check("midair_no_land_errors", n_land, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
